fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Multi-cycle instruction-fetch controller for the RV32EC core. It sequences word-wide memory reads for the current program-counter address and assembles 16- or 32-bit instructions, including 32-bit instructions that straddle a word boundary. It drives the program counter's hold input so that the PC advances only when an instruction has been issued and execution has released it. It also flags fetch faults: misaligned PC and memory timeout.

Parameters:
MAX_WAIT, 255, memory wait cycles (req high, no ack) before fetch fault; legal range 1..65535
CNT_W, 16, timeout counter width; must satisfy 2^CNT_W > MAX_WAIT

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pc_addr  in  32  current PC value from program counter
exec_stall  in  1  decode/execute needs more cycles on the issued instruction
mem_req  out  1  memory read request
mem_addr  out  32  word-aligned read address, bits [1:0] always 0
mem_ack  in  1  read complete; mem_rdata valid this cycle
mem_rdata  in  32  read data
instr  out  32  assembled instruction; compressed forms zero-extended in [31:16]
instr_valid  out  1  instr valid for decode
compressed  out  1  instr is 16-bit (drives PC increment select)
pc_hold  out  1  1 = PC must not update this cycle (feeds multi-cycle control)
fetch_fault  out  1  sticky fault flag

Behaviour:
- Reset (async): state IDLE, mem_req=0, mem_addr=0, instr=0, instr_valid=0, compressed=0, pc_hold=1, fetch_fault=0, halfword buffer and timeout counter cleared.
- IDLE: lasts exactly one cycle after rst deasserts, then goes to REQ_LO.
- REQ_LO entry check: if pc_addr[0]=1, go to FAULT with no request issued.
- REQ_LO: mem_req=1, mem_addr={pc_addr[31:2],2'b00}. Ack may arrive in the first req cycle. On mem_ack, select the halfword H: mem_rdata[15:0] if pc_addr[1]=0, else mem_rdata[31:16].
  - H[1:0]!=2'b11: compressed instruction; instr={16'h0,H}, compressed=1, go to ISSUE.
  - H[1:0]=2'b11 and pc_addr[1]=0: 32-bit instruction; instr=mem_rdata, compressed=0, go to ISSUE.
  - H[1:0]=2'b11 and pc_addr[1]=1: buffer H and go to REQ_HI.
- REQ_HI: mem_req=1, mem_addr={pc_addr[31:2],2'b00}+4, wrapping modulo 2^32. On mem_ack: instr={mem_rdata[15:0],buffered H}, compressed=0, go to ISSUE.
- Request handshake:
  - mem_addr is stable while mem_req=1.
  - mem_req drops for at least one cycle between instruction fetches. Between REQ_LO and REQ_HI it stays high and mem_addr changes on the ack edge.
  - mem_ack is ignored while mem_req=0.
- ISSUE: instr_valid=1 and instr/compressed held stable.
  - exec_stall=1: stay in ISSUE with pc_hold=1.
  - exec_stall=0: pc_hold=0 for exactly this cycle (PC updates on this edge), then go to REQ_LO.
- pc_hold=1 in every state except the single releasing ISSUE cycle.
- Timeout: counter increments each cycle in REQ_LO/REQ_HI without ack and clears on ack or state exit. When it reaches MAX_WAIT, go to FAULT.
- FAULT: mem_req=0, instr_valid=0, pc_hold=1, fetch_fault=1. Only rst exits FAULT.
- Reset mid-request: outputs return to reset values immediately. Any late mem_ack is ignored because mem_req=0.
- pc_addr is sampled combinationally each fetch state and is stable because pc_hold=1.

Test Plan:
- pc=0x00, mem[0]=0x00A00093, ack after 2 cycles -> instr=0x00A00093, compressed=0, pc_hold low one cycle; next mem_addr follows new pc.
- pc=0x04, mem[4]=0x12344501 -> instr=0x00004501, compressed=1, one request only.
- pc=0x06, mem[4]=0x00B34501 -> instr=0x000000B3? No: H=0x00B3 has [1:0]=11, so REQ_HI addr 0x08; with mem[8]=0xABCD0010 -> instr=0x001000B3, compressed=0, two requests, mem_req high continuously.
- ISSUE with exec_stall high 3 cycles -> instr_valid high 4 cycles, pc_hold low only in the 4th, instr unchanged throughout.
- MAX_WAIT=4, no ack -> fetch_fault=1 after 4 req cycles, mem_req=0, stays faulted; pc=0x03 -> immediate FAULT, no mem_req.
- rst asserted during REQ_HI with ack arriving the same cycle -> all outputs at reset values, no instr_valid; fetch restarts at REQ_LO two cycles after rst release.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for the RV32EC core.
// Issues word reads for the current PC, assembles 16-bit and 32-bit
// instructions (including 32-bit ones straddling a word boundary),
// gates the PC through pc_hold and latches a sticky fetch fault on a
// misaligned PC or a memory that never acknowledges.
module fetch_sequencer #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_addr,
    input  logic        exec_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        compressed,
    output logic        pc_hold,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_LO,
        REQ_HI,
        ISSUE,
        FAULT
    } state_t;

    // Counter value seen in the last request cycle allowed before the fault.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    state_t           state;
    logic [15:0]      half_buf;
    logic [CNT_W-1:0] wait_cnt;

    logic [15:0]      first_half;
    logic [31:0]      pc_word;
    logic             timed_out;

    // Pick the halfword addressed by the PC out of a fetched word.
    function automatic logic [15:0] select_half(input logic [31:0] word,
                                                input logic        upper);
        return upper ? word[31:16] : word[15:0];
    endfunction

    // RV32C encoding: low two bits 11 mark a full 32-bit instruction.
    function automatic logic is_full_width(input logic [15:0] half);
        return half[1:0] == 2'b11;
    endfunction

    assign first_half = select_half(mem_rdata, pc_addr[1]);
    assign pc_word    = {pc_addr[31:2], 2'b00};
    assign timed_out  = (wait_cnt == LAST_WAIT);

    // The PC may only move in the ISSUE cycle where execution releases the
    // instruction; this has to follow exec_stall within the same cycle, so
    // it is decoded from the registered state rather than registered itself.
    assign pc_hold = !((state == ISSUE) && !exec_stall);

    // Fetch state machine with registered memory and instruction outputs.
    // REQ_LO spends its first cycle with mem_req low: this checks the freshly
    // updated PC for misalignment and guarantees the request gap between
    // consecutive instruction fetches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= 32'h0;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            compressed  <= 1'b0;
            fetch_fault <= 1'b0;
            half_buf    <= 16'h0;
            wait_cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= REQ_LO;
                end

                REQ_LO: begin
                    if (!mem_req) begin
                        if (pc_addr[0]) begin
                            fetch_fault <= 1'b1;
                            state       <= FAULT;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= pc_word;
                            wait_cnt <= '0;
                        end
                    end else if (mem_ack) begin
                        wait_cnt <= '0;
                        if (!is_full_width(first_half)) begin
                            instr       <= {16'h0, first_half};
                            compressed  <= 1'b1;
                            instr_valid <= 1'b1;
                            mem_req     <= 1'b0;
                            state       <= ISSUE;
                        end else if (!pc_addr[1]) begin
                            instr       <= mem_rdata;
                            compressed  <= 1'b0;
                            instr_valid <= 1'b1;
                            mem_req     <= 1'b0;
                            state       <= ISSUE;
                        end else begin
                            // Upper half of this word starts a 32-bit
                            // instruction: keep the request up and move to
                            // the next word (address wraps at 2^32).
                            half_buf <= first_half;
                            mem_addr <= pc_word + 32'd4;
                            state    <= REQ_HI;
                        end
                    end else if (timed_out) begin
                        mem_req     <= 1'b0;
                        wait_cnt    <= '0;
                        fetch_fault <= 1'b1;
                        state       <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                REQ_HI: begin
                    if (mem_ack) begin
                        instr       <= {mem_rdata[15:0], half_buf};
                        compressed  <= 1'b0;
                        instr_valid <= 1'b1;
                        mem_req     <= 1'b0;
                        wait_cnt    <= '0;
                        state       <= ISSUE;
                    end else if (timed_out) begin
                        mem_req     <= 1'b0;
                        wait_cnt    <= '0;
                        fetch_fault <= 1'b1;
                        state       <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                ISSUE: begin
                    if (!exec_stall) begin
                        instr_valid <= 1'b0;
                        state       <= REQ_LO;
                    end
                end

                FAULT: begin
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_fault <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
